// File: rtl/m_imem_arbiter_pkg.sv
// m_imem_arbiter_pkg: shared state encoding and port indices for the memory read arbiter
package m_imem_arbiter_pkg;
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;
    localparam logic P_FETCH = 1'b0;
    localparam logic P_LOAD  = 1'b1;
endpackage

// File: rtl/m_imem_arbiter_rr_arb2.sv
// m_rr_arb2: two-way round-robin pick
//   req0/req1 : requests
//   last      : port granted most recently
//   gnt       : picked port, meaningful when vld is high
//   vld       : at least one request present
module m_rr_arb2 (
    input  logic req0,
    input  logic req1,
    input  logic last,
    output logic gnt,
    output logic vld
);
    assign vld = req0 | req1;
    assign gnt = (req0 & req1) ? ~last : req1;
endmodule

// File: rtl/m_imem_arbiter.sv
// m_imem_arbiter: round-robin arbiter and sequencer for a multi-cycle read memory
//   w_clk, w_rst_n         : clock, asynchronous active-low reset
//   w_req*/w_addr*         : fetch (0) and load (1) read requests
//   r_ack*/r_data*/r_err   : one-cycle completion, data and timeout flag
//   r_mem_re/r_mem_addr    : one-cycle read request and address to memory
//   w_mem_oe/w_mem_data    : memory response strobe and data
module m_imem_arbiter
    import m_imem_arbiter_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              w_clk,
    input  logic              w_rst_n,
    input  logic              w_req0,
    input  logic              w_req1,
    input  logic [ADDR_W-1:0] w_addr0,
    input  logic [ADDR_W-1:0] w_addr1,
    output logic              r_ack0,
    output logic              r_ack1,
    output logic [DATA_W-1:0] r_data0,
    output logic [DATA_W-1:0] r_data1,
    output logic              r_err,
    output logic              r_mem_re,
    output logic [ADDR_W-1:0] r_mem_addr,
    input  logic              w_mem_oe,
    input  logic [DATA_W-1:0] w_mem_data
);
    localparam int CW = $clog2(TIMEOUT + 1);
    state_t        state;
    logic          r_owner;
    logic          r_last;
    logic [CW-1:0] cnt;
    logic          gnt;
    logic          gnt_vld;
    logic          timeout;
    m_rr_arb2 u_arb (
        .req0 (w_req0),
        .req1 (w_req1),
        .last (r_last),
        .gnt  (gnt),
        .vld  (gnt_vld)
    );
    assign timeout = cnt == CW'(TIMEOUT - 1);
    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            state      <= S_IDLE;
            r_owner    <= P_FETCH;
            r_last     <= P_LOAD;
            cnt        <= '0;
            r_mem_re   <= 1'b0;
            r_mem_addr <= '0;
            r_ack0     <= 1'b0;
            r_ack1     <= 1'b0;
            r_data0    <= '0;
            r_data1    <= '0;
            r_err      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (gnt_vld) begin
                    state      <= S_ISSUE;
                    r_owner    <= gnt;
                    r_last     <= gnt;
                    r_mem_addr <= (gnt == P_LOAD) ? w_addr1 : w_addr0;
                    r_mem_re   <= 1'b1;
                end
                S_ISSUE: begin
                    state    <= S_WAIT;
                    r_mem_re <= 1'b0;
                    cnt      <= '0;
                end
                // oe wins over a coincident timeout; a timeout returns zero data
                S_WAIT: if (w_mem_oe || timeout) begin
                    state      <= S_DONE;
                    r_ack0     <= r_owner == P_FETCH;
                    r_ack1     <= r_owner == P_LOAD;
                    r_data0    <= (r_owner == P_FETCH && w_mem_oe) ? w_mem_data : '0;
                    r_data1    <= (r_owner == P_LOAD && w_mem_oe) ? w_mem_data : '0;
                    r_err      <= !w_mem_oe;
                    r_mem_addr <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
                S_DONE: begin
                    state   <= S_IDLE;
                    r_ack0  <= 1'b0;
                    r_ack1  <= 1'b0;
                    r_data0 <= '0;
                    r_data1 <= '0;
                    r_err   <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_m_imem_arbiter.sv
// tb_m_imem_arbiter: directed self-checking bench for m_imem_arbiter
module tb_m_imem_arbiter;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0, req1;
    logic [31:0] addr0, addr1;
    logic        ack0, ack1, err, mem_re, mem_oe;
    logic [31:0] data0, data1, mem_addr, mem_data;
    int          n_tests = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          last_ack = 0;
    int          k = 0;
    logic        exp_p;

    always #5 clk = ~clk;

    m_imem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(16)) dut (
        .w_clk      (clk),
        .w_rst_n    (rst_n),
        .w_req0     (req0),
        .w_req1     (req1),
        .w_addr0    (addr0),
        .w_addr1    (addr1),
        .r_ack0     (ack0),
        .r_ack1     (ack1),
        .r_data0    (data0),
        .r_data1    (data1),
        .r_err      (err),
        .r_mem_re   (mem_re),
        .r_mem_addr (mem_addr),
        .w_mem_oe   (mem_oe),
        .w_mem_data (mem_data)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic wait_re(input string tag);
        int n = 0;
        while (!mem_re && n < 20) begin
            step();
            n++;
        end
        chk(tag, mem_re, 1);
    endtask

    // memory with D=3: oe two cycles after the re cycle
    task automatic serve(input logic [31:0] d);
        step();
        step();
        mem_oe = 1'b1;
        mem_data = d;
        step();
        mem_oe = 1'b0;
        mem_data = '0;
    endtask

    task automatic all_zero(input string tag);
        chk({tag, "_re"}, mem_re, 0);
        chk({tag, "_addr"}, mem_addr, 0);
        chk({tag, "_ack0"}, ack0, 0);
        chk({tag, "_ack1"}, ack1, 0);
        chk({tag, "_data0"}, data0, 0);
        chk({tag, "_data1"}, data1, 0);
        chk({tag, "_err"}, err, 0);
    endtask

    initial begin
        rst_n = 1'b0;
        req0 = 1'b0;
        req1 = 1'b0;
        addr0 = '0;
        addr1 = '0;
        mem_oe = 1'b0;
        mem_data = '0;
        step();
        step();
        all_zero("reset");
        rst_n = 1'b1;
        step();

        mem_oe = 1'b1;
        mem_data = 32'h1234;
        step();
        mem_oe = 1'b0;
        mem_data = '0;
        all_zero("stray");
        step();
        all_zero("stray_after");

        req0 = 1'b1;
        addr0 = 32'h40;
        step();
        chk("single_re_t1", mem_re, 1);
        chk("single_addr", mem_addr, 32'h40);
        serve(32'hDEADBEEF);
        req0 = 1'b0;
        chk("single_ack0", ack0, 1);
        chk("single_data0", data0, 32'hDEADBEEF);
        chk("single_ack1", ack1, 0);
        chk("single_err", err, 0);
        step();
        chk("single_ack0_end", ack0, 0);
        chk("single_data0_end", data0, 0);

        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        req0 = 1'b1;
        req1 = 1'b1;
        addr0 = 32'hA0;
        addr1 = 32'hB0;
        for (int i = 0; i < 3; i++) begin
            exp_p = (i == 1);
            wait_re("sim_re");
            chk("sim_addr", mem_addr, exp_p ? 32'hB0 : 32'hA0);
            serve(32'h1000 + i);
            chk("sim_ack0", ack0, !exp_p);
            chk("sim_ack1", ack1, exp_p);
            chk("sim_data", exp_p ? data1 : data0, 32'h1000 + i);
            if (i > 0) chk("sim_spacing", cyc - last_ack, 5);
            last_ack = cyc;
        end
        req0 = 1'b0;
        req1 = 1'b0;
        step();
        step();
        chk("sim_idle_re", mem_re, 0);

        req1 = 1'b1;
        addr1 = 32'h100;
        wait_re("to_re");
        chk("to_addr", mem_addr, 32'h100);
        k = 0;
        while (!ack1 && k < 40) begin
            step();
            k++;
        end
        chk("to_latency", k, 17);
        chk("to_err", err, 1);
        chk("to_data1", data1, 0);
        chk("to_ack0", ack0, 0);
        req1 = 1'b0;
        step();
        chk("to_ack1_end", ack1, 0);
        chk("to_err_end", err, 0);

        req0 = 1'b1;
        addr0 = 32'h80;
        wait_re("rst_re");
        step();
        step();
        chk("rst_pre_addr", mem_addr, 32'h80);
        rst_n = 1'b0;
        #1;
        all_zero("rst_async");
        step();
        rst_n = 1'b1;
        req0 = 1'b0;
        mem_oe = 1'b1;
        mem_data = 32'h5555;
        step();
        mem_oe = 1'b0;
        mem_data = '0;
        all_zero("rst_late_oe");
        req0 = 1'b1;
        addr0 = 32'h84;
        wait_re("rst_again_re");
        chk("rst_again_addr", mem_addr, 32'h84);
        serve(32'hCAFEF00D);
        req0 = 1'b0;
        chk("rst_again_ack0", ack0, 1);
        chk("rst_again_data0", data0, 32'hCAFEF00D);
        step();

        req0 = 1'b1;
        addr0 = 32'hC0;
        wait_re("wd_re");
        step();
        req0 = 1'b0;
        step();
        mem_oe = 1'b1;
        mem_data = 32'h13572468;
        step();
        mem_oe = 1'b0;
        mem_data = '0;
        chk("wd_ack0", ack0, 1);
        chk("wd_data0", data0, 32'h13572468);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("wd_no_re", mem_re, 0);
        end
        chk("wd_ack0_end", ack0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
